// File: rtl/mbisr_chain_ctrl.sv
// mbisr_chain_ctrl: serial access controller for an MBISR repair-register chain.
// Byte streams in/out are LSB-first; the chain is clock-gated through CHAIN_CLK_EN.
module mbisr_chain_ctrl #(
    parameter int CHAIN_LEN = 22,
    parameter int CNT_W = $clog2(CHAIN_LEN + 1)
) (
    input  logic       CLK,
    input  logic       RSTB,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic       din_valid,
    output logic       din_ready,
    input  logic [7:0] din_data,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic [7:0] dout_data,
    output logic       CHAIN_CLK_EN,
    output logic       SE,
    output logic       SI,
    input  logic       SO,
    output logic       busy,
    output logic       done,
    output logic       mismatch
);
    typedef enum logic [2:0] {IDLE, CAPT, SHIFT, FLUSH, DONE} state_e;
    localparam logic [1:0] OP_LOAD = 2'd0, OP_UNLOAD = 2'd1, OP_VERIFY = 2'd2, OP_CAPTURE = 2'd3;
    localparam logic [CNT_W-1:0] LEN = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

    state_e state_q, state_d;
    logic [1:0] op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0] hold_q, hold_d, acc_q, acc_d, dout_data_q, dout_data_d, samp;
    logic hold_v_q, hold_v_d, dout_valid_q, dout_valid_d, mismatch_q, mismatch_d;
    logic cmd_ready_q, busy_q, done_q, se_q;
    logic [2:0] bidx;
    logic in_shift, feed_op, last_bit, byte_end, shift, accept;

    // Bytes are aligned to the chain start, so the counter's low bits index both buffers.
    assign bidx = 3'(cnt_q);
    assign in_shift = state_q == SHIFT;
    assign feed_op = op_q == OP_LOAD || op_q == OP_VERIFY;
    assign last_bit = cnt_q == LAST;
    assign byte_end = bidx == 3'd7 || last_bit;
    assign shift = in_shift && cnt_q < LEN &&
                   (feed_op ? hold_v_q : !(byte_end && dout_valid_q && !dout_ready));
    assign accept = state_q == IDLE && cmd_valid && cmd_ready_q;
    assign samp = acc_q | (8'(SO) << bidx);

    // Refill may overlap the last-bit consumption, but never fetch past the chain end.
    assign din_ready = in_shift && feed_op && (!hold_v_q || (shift && byte_end)) && !(shift && last_bit);
    assign CHAIN_CLK_EN = state_q == CAPT || shift;
    assign SI = in_shift && (op_q == OP_LOAD ? hold_q[bidx] : SO);

    assign cmd_ready = cmd_ready_q;
    assign busy = busy_q;
    assign done = done_q;
    assign SE = se_q;
    assign dout_valid = dout_valid_q;
    assign dout_data = dout_data_q;
    assign mismatch = mismatch_q;

    always_comb begin
        state_d = state_q;
        op_d = op_q;
        cnt_d = cnt_q;
        hold_d = hold_q;
        hold_v_d = hold_v_q;
        acc_d = acc_q;
        dout_data_d = dout_data_q;
        dout_valid_d = dout_valid_q && !dout_ready;
        mismatch_d = mismatch_q;
        if (accept) begin
            op_d = cmd_op;
            cnt_d = '0;
            acc_d = '0;
            hold_v_d = 1'b0;
            mismatch_d = 1'b0;
        end
        if (shift) begin
            cnt_d = cnt_q + 1'b1;
            acc_d = byte_end ? 8'h00 : samp;
            hold_v_d = hold_v_q && !byte_end;
            if (op_q == OP_UNLOAD && byte_end) begin
                dout_data_d = samp;
                dout_valid_d = 1'b1;
            end
            if (op_q == OP_VERIFY && SO != hold_q[bidx]) mismatch_d = 1'b1;
        end
        if (din_valid && din_ready) begin
            hold_d = din_data;
            hold_v_d = 1'b1;
        end
        unique case (state_q)
            IDLE:    if (accept) state_d = cmd_op == OP_CAPTURE ? CAPT : SHIFT;
            CAPT:    state_d = DONE;
            SHIFT:   if (shift && last_bit) state_d = op_q == OP_UNLOAD ? FLUSH : DONE;
            FLUSH:   if (dout_valid_q && dout_ready) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q <= IDLE;
            op_q <= OP_LOAD;
            cnt_q <= '0;
            hold_q <= '0;
            hold_v_q <= 1'b0;
            acc_q <= '0;
            dout_data_q <= '0;
            dout_valid_q <= 1'b0;
            mismatch_q <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            se_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q <= op_d;
            cnt_q <= cnt_d;
            hold_q <= hold_d;
            hold_v_q <= hold_v_d;
            acc_q <= acc_d;
            dout_data_q <= dout_data_d;
            dout_valid_q <= dout_valid_d;
            mismatch_q <= mismatch_d;
            cmd_ready_q <= state_d == IDLE;
            busy_q <= state_d != IDLE;
            done_q <= state_d == DONE;
            se_q <= state_d == SHIFT;
        end
    end
endmodule

// File: tb/tb_mbisr_chain_ctrl.sv
// tb_mbisr_chain_ctrl: directed bench with a 22-bit chain model and an output-byte scoreboard.
module tb_mbisr_chain_ctrl;
    localparam int L = 22;

    logic CLK = 1'b0, RSTB = 1'b1, cmd_valid = 1'b0, din_valid = 1'b0, dout_ready = 1'b1, SO = 1'b0;
    logic [1:0] cmd_op = 2'd0;
    logic [7:0] din_data = 8'h00;
    logic cmd_ready, din_ready, dout_valid, CHAIN_CLK_EN, SE, SI, busy, done, mismatch;
    logic [7:0] dout_data;

    mbisr_chain_ctrl #(.CHAIN_LEN(L)) dut (
        .CLK(CLK), .RSTB(RSTB), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
        .CHAIN_CLK_EN(CHAIN_CLK_EN), .SE(SE), .SI(SI), .SO(SO),
        .busy(busy), .done(done), .mismatch(mismatch)
    );

    always #5 CLK = ~CLK;

    // Chain model: SO end is bit 0, scan-in enters at the top, SO retimed on negedge.
    logic [L-1:0] chain = '0;
    logic [L-1:0] cap_d = 22'h155555;
    always @(posedge CLK) if (CHAIN_CLK_EN) chain <= SE ? {SI, chain[L-1:1]} : cap_d;
    always @(negedge CLK) SO <= chain[0];

    // dout_ready pattern: 0 = always ready, 1 = toggling, 2 = held low
    int mode = 0;
    always @(negedge CLK) dout_ready = (mode == 1) ? ~dout_ready : (mode == 0);

    int cyc = 0, shifts = 0, caps = 0, frozen = 0, dones = 0;
    int last_shift_cyc = 0, done_cyc = 0, acc_cyc = 0, hs_cyc = 0;
    logic [L-1:0] si_vec = '0;
    logic [7:0] got[$];
    always begin
        @(negedge CLK);
        #2;
        if (RSTB) begin
            cyc++;
            if (CHAIN_CLK_EN && SE) begin
                shifts++;
                last_shift_cyc = cyc;
                si_vec = {SI, si_vec[L-1:1]};
            end
            if (CHAIN_CLK_EN && !SE) caps++;
            if (SE && !CHAIN_CLK_EN) frozen++;
            if (done) begin
                dones++;
                done_cyc = cyc;
            end
            if (cmd_valid && cmd_ready) acc_cyc = cyc;
            if (dout_valid && dout_ready) begin
                got.push_back(dout_data);
                hs_cyc = cyc;
            end
        end
    end

    int checks = 0, errors = 0, rd = 0;
    logic [7:0] exp_q[$];
    int bs, bf, bd, bc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [1:0] op, input logic [7:0] b0, input bit feed);
        @(negedge CLK);
        cmd_valid = 1'b1;
        cmd_op = op;
        if (feed) begin
            din_valid = 1'b1;
            din_data = b0;
        end
        @(negedge CLK);
        cmd_valid = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        int n = 0;
        din_valid = 1'b1;
        din_data = b;
        #3;
        while (!din_ready && n < 100) begin
            @(negedge CLK);
            #3;
            n++;
        end
        chk("din_handshake_in_time", n < 100, 1);
        @(negedge CLK);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (dones == bd && n < 300) begin
            @(negedge CLK);
            #3;
            n++;
        end
        chk(tag, dones - bd, 1);
    endtask

    task automatic snap();
        bs = shifts;
        bf = frozen;
        bd = dones;
        bc = caps;
    endtask

    task automatic check_out(input string tag);
        chk({tag, "_count"}, got.size() - rd, exp_q.size());
        while (exp_q.size() > 0 && rd < got.size()) begin
            chk(tag, got[rd], exp_q.pop_front());
            rd++;
        end
        exp_q.delete();
        rd = got.size();
    endtask

    initial begin
        #1 RSTB = 1'b0;
        #2;
        chk("reset_outputs", {cmd_ready, din_ready, dout_valid, dout_data, CHAIN_CLK_EN, SE, SI, busy, done, mismatch}, 0);
        @(negedge CLK);
        RSTB = 1'b1;
        @(negedge CLK);
        #3;
        chk("cmd_ready_after_release", {cmd_ready, busy}, 2'b10);

        snap();
        start(2'd0, 8'hA5, 1);
        push_byte(8'hA5);
        push_byte(8'h3C);
        push_byte(8'h2F);
        din_valid = 1'b0;
        wait_done("load_done");
        chk("load_shifts", shifts - bs, L);
        chk("load_frozen", frozen - bf, 1);
        chk("load_done_latency", done_cyc - last_shift_cyc, 1);
        chk("load_si_stream", si_vec, 22'h2F3CA5);
        chk("load_chain", chain, 22'h2F3CA5);

        snap();
        mode = 1;
        exp_q = '{8'hA5, 8'h3C, 8'h2F};
        start(2'd1, 8'h00, 0);
        wait_done("unload_toggle_done");
        check_out("unload_toggle_byte");
        chk("unload_toggle_shifts", shifts - bs, L);
        chk("unload_done_latency", done_cyc - hs_cyc, 1);
        chk("unload_chain_kept", chain, 22'h2F3CA5);

        snap();
        mode = 2;
        exp_q = '{8'hA5, 8'h3C, 8'h2F};
        start(2'd1, 8'h00, 0);
        repeat (30) @(negedge CLK);
        mode = 0;
        wait_done("unload_stall_done");
        check_out("unload_stall_byte");
        chk("unload_stalled", (frozen - bf) > 0, 1);
        chk("unload_stall_shifts", shifts - bs, L);
        chk("unload_stall_chain_kept", chain, 22'h2F3CA5);

        snap();
        start(2'd2, 8'hA5, 1);
        push_byte(8'hA5);
        push_byte(8'h3C);
        push_byte(8'h2F);
        din_valid = 1'b0;
        wait_done("verify_ok_done");
        chk("verify_ok_mismatch", mismatch, 0);
        chk("verify_ok_chain", chain, 22'h2F3CA5);

        snap();
        start(2'd2, 8'hA5, 1);
        push_byte(8'hA5);
        push_byte(8'h3E);
        push_byte(8'h2F);
        din_valid = 1'b0;
        wait_done("verify_bad_done");
        chk("verify_bad_mismatch", mismatch, 1);
        repeat (3) @(negedge CLK);
        #3;
        chk("verify_mismatch_sticky", mismatch, 1);

        snap();
        start(2'd3, 8'h00, 0);
        #3;
        chk("mismatch_cleared_on_accept", mismatch, 0);
        wait_done("capture_done");
        chk("capture_pulses", caps - bc, 1);
        chk("capture_latency", done_cyc - acc_cyc, 2);
        chk("capture_chain", chain, 22'h155555);

        snap();
        exp_q = '{8'h55, 8'h55, 8'h15};
        start(2'd1, 8'h00, 0);
        wait_done("unload_capture_done");
        check_out("unload_capture_byte");

        snap();
        start(2'd0, 8'hA5, 1);
        push_byte(8'hA5);
        din_valid = 1'b0;
        repeat (12) @(negedge CLK);
        push_byte(8'h3C);
        push_byte(8'h2F);
        din_valid = 1'b0;
        wait_done("load_gap_done");
        chk("load_gap_frozen", frozen - bf, 6);
        chk("load_gap_shifts", shifts - bs, L);
        chk("load_gap_chain", chain, 22'h2F3CA5);

        snap();
        start(2'd0, 8'h5A, 1);
        push_byte(8'h5A);
        push_byte(8'hC3);
        begin
            int n = 0;
            while (shifts - bs < 10 && n < 100) begin
                @(negedge CLK);
                #3;
                n++;
            end
        end
        chk("reset_mid_load_reached", shifts - bs, 10);
        RSTB = 1'b0;
        din_valid = 1'b0;
        #1;
        chk("reset_mid_load_outputs", {cmd_ready, din_ready, dout_valid, dout_data, CHAIN_CLK_EN, SE, SI, busy, done, mismatch}, 0);
        repeat (3) @(negedge CLK);
        RSTB = 1'b1;
        repeat (3) @(negedge CLK);
        #3;
        chk("reset_mid_load_no_done", dones - bd, 0);
        snap();
        start(2'd3, 8'h00, 0);
        wait_done("after_reset_capture_done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
